// File: rtl/sp_counter.sv
// Bounded, loadable stack pointer: push decrements and pop increments by STEP within [LIMIT, TOP].
// Define SP_WRAP_EN for circular-stack mode: an out-of-bounds push/pop wraps sp instead of holding it.
module sp_counter #(
  parameter int unsigned      WIDTH = 14,
  parameter logic [WIDTH-1:0] TOP   = '1,
  parameter logic [WIDTH-1:0] LIMIT = '0,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] sp,
  output logic [WIDTH-1:0] sp_dec,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  // One extra bit so LIMIT+STEP and sp+STEP cannot alias through a carry.
  logic [WIDTH:0] lim_bound;
  logic [WIDTH:0] pop_sum;
  logic           pop_ok;

  assign lim_bound = {1'b0, LIMIT} + {1'b0, STEP};
  assign pop_sum   = {1'b0, sp} + {1'b0, STEP};
  assign pop_ok    = pop_sum <= {1'b0, TOP};

  assign full   = {1'b0, sp} < lim_bound;
  assign empty  = sp == TOP;
  assign sp_dec = sp - STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= TOP;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Cleared first so that a same-cycle error below re-sets its flag.
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (load) begin
        sp <= load_val;
      end else if (push && !pop) begin
        if (!full) begin
          sp <= sp - STEP;
        end else begin
          overflow <= 1'b1;
`ifdef SP_WRAP_EN
          sp <= TOP;
`else
          sp <= sp;
`endif
        end
      end else if (pop && !push) begin
        if (pop_ok) begin
          sp <= pop_sum[WIDTH-1:0];
        end else begin
          underflow <= 1'b1;
`ifdef SP_WRAP_EN
          sp <= LIMIT;
`else
          sp <= sp;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sp_counter.sv
// Randomized bench for sp_counter: two parameterisations checked every cycle against an integer model.
module tb_sp_counter;

  localparam int TOP_C        = 16383;
  localparam int MOD_C        = 16384;
  localparam int LIM_C  [2]   = '{0, 256};
  localparam int STEP_C [2]   = '{1, 4};

  logic        clk = 1'b0;
  logic        reset = 1'b0, push = 1'b0, pop = 1'b0, load = 1'b0, clr_err = 1'b0;
  logic [13:0] load_val = '0;

  logic [13:0] sp_w     [2];
  logic [13:0] sp_dec_w [2];
  logic        empty_w  [2];
  logic        full_w   [2];
  logic        ovf_w    [2];
  logic        unf_w    [2];

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  int m_sp [2];
  int m_ov [2];
  int m_un [2];

  always #5 clk = ~clk;

  sp_counter #(.WIDTH(14), .TOP(14'h3FFF), .LIMIT(14'h0000), .STEP(14'd1)) u_a (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .load(load), .load_val(load_val),
    .clr_err(clr_err), .sp(sp_w[0]), .sp_dec(sp_dec_w[0]), .empty(empty_w[0]),
    .full(full_w[0]), .overflow(ovf_w[0]), .underflow(unf_w[0]));

  sp_counter #(.WIDTH(14), .TOP(14'h3FFF), .LIMIT(14'h0100), .STEP(14'd4)) u_b (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .load(load), .load_val(load_val),
    .clr_err(clr_err), .sp(sp_w[1]), .sp_dec(sp_dec_w[1]), .empty(empty_w[1]),
    .full(full_w[1]), .overflow(ovf_w[1]), .underflow(unf_w[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: plain integer arithmetic on the stack-pointer rules.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_sp[i] = TOP_C; m_ov[i] = 0; m_un[i] = 0;
      end else begin
        if (clr_err) begin m_ov[i] = 0; m_un[i] = 0; end
        if (load) m_sp[i] = int'(load_val);
        else if (push && !pop) begin
          if (m_sp[i] - STEP_C[i] >= LIM_C[i]) m_sp[i] = m_sp[i] - STEP_C[i];
          else begin
            m_ov[i] = 1;
`ifdef SP_WRAP_EN
            m_sp[i] = TOP_C;
`endif
          end
        end else if (pop && !push) begin
          if (m_sp[i] + STEP_C[i] <= TOP_C) m_sp[i] = m_sp[i] + STEP_C[i];
          else begin
            m_un[i] = 1;
`ifdef SP_WRAP_EN
            m_sp[i] = LIM_C[i];
`endif
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("sp[%0d]", i),        32'(sp_w[i]),     32'(m_sp[i]));
        chk($sformatf("sp_dec[%0d]", i),    32'(sp_dec_w[i]), 32'((m_sp[i] - STEP_C[i] + MOD_C) % MOD_C));
        chk($sformatf("empty[%0d]", i),     32'(empty_w[i]),  32'(m_sp[i] == TOP_C));
        chk($sformatf("full[%0d]", i),      32'(full_w[i]),   32'(m_sp[i] < LIM_C[i] + STEP_C[i]));
        chk($sformatf("overflow[%0d]", i),  32'(ovf_w[i]),    32'(m_ov[i]));
        chk($sformatf("underflow[%0d]", i), 32'(unf_w[i]),    32'(m_un[i]));
      end
    end
  end

  task automatic step(input bit r, input bit pu, input bit po, input bit ld,
                      input logic [13:0] lv, input bit ce);
    reset = r; push = pu; pop = po; load = ld; load_val = lv; clr_err = ce;
    @(posedge clk);
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0; load = 1'b0; clr_err = 1'b0;
  endtask

  function automatic logic [13:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 14'h0000;
      1: return 14'h0001;
      2: return 14'(14'h0100 + $urandom_range(0, 8));
      3: return 14'h3FFF;
      4: return 14'(14'h3FFF - $urandom_range(0, 5));
      default: return 14'($urandom);
    endcase
  endfunction

  initial begin
    @(posedge clk); #1;
    // 1: reset state
    step(1, 0, 0, 0, '0, 0);
    cmp_en = 1'b1;
    chk("t1_sp", 32'(sp_w[0]), 32'h3FFF);
    chk("t1_sp_dec", 32'(sp_dec_w[0]), 32'h3FFE);
    chk("t1_empty", 32'(empty_w[0]), 32'd1);
    chk("t1_full", 32'(full_w[0]), 32'd0);
    chk("t1_flags", {30'd0, ovf_w[0], unf_w[0]}, 32'd0);
    chk("t1_model_sp", 32'(m_sp[0]), 32'h3FFF);
    // 2: push x3, pop, simultaneous push/pop
    repeat (3) step(0, 1, 0, 0, '0, 0);
    chk("t2_push3", 32'(sp_w[0]), 32'h3FFC);
    chk("t2_model_push3", 32'(m_sp[0]), 32'h3FFC);
    step(0, 0, 1, 0, '0, 0);
    chk("t2_pop", 32'(sp_w[0]), 32'h3FFD);
    step(0, 1, 1, 0, '0, 0);
    chk("t2_pushpop", 32'(sp_w[0]), 32'h3FFD);
    // 3: underflow at empty, then clear
    step(1, 0, 0, 0, '0, 0);
    step(0, 0, 1, 0, '0, 0);
    chk("t3_underflow", 32'(unf_w[0]), 32'd1);
`ifdef SP_WRAP_EN
    chk("t3_sp", 32'(sp_w[0]), 32'h0000);
`else
    chk("t3_sp", 32'(sp_w[0]), 32'h3FFF);
`endif
    step(0, 0, 0, 0, '0, 1);
    chk("t3_clr", 32'(unf_w[0]), 32'd0);
    // 4: overflow at sp=0
    step(0, 0, 0, 1, 14'h0000, 0);
    chk("t4_sp_dec_at0", 32'(sp_dec_w[0]), 32'h3FFF);
    chk("t4_full_at0", 32'(full_w[0]), 32'd1);
    step(0, 1, 0, 0, '0, 0);
    chk("t4_overflow", 32'(ovf_w[0]), 32'd1);
`ifdef SP_WRAP_EN
    chk("t4_sp", 32'(sp_w[0]), 32'h3FFF);
`else
    chk("t4_sp", 32'(sp_w[0]), 32'h0000);
    chk("t4_full", 32'(full_w[0]), 32'd1);
`endif
    // 5: STEP=4, LIMIT=0x100 instance
    step(1, 0, 0, 0, '0, 0);
    step(0, 0, 0, 1, 14'h0103, 0);
    step(0, 1, 0, 0, '0, 0);
    chk("t5_overflow_b", 32'(ovf_w[1]), 32'd1);
`ifdef SP_WRAP_EN
    chk("t5_sp_b", 32'(sp_w[1]), 32'h3FFF);
`else
    chk("t5_sp_b", 32'(sp_w[1]), 32'h0103);
`endif
    step(0, 0, 0, 1, 14'h0104, 0);
    step(0, 1, 0, 0, '0, 0);
    chk("t5_sp_b_min", 32'(sp_w[1]), 32'h0100);
    chk("t5_full_b", 32'(full_w[1]), 32'd1);
    chk("t5_model_b", 32'(m_sp[1]), 32'h0100);
    // 6: reset discards same-cycle load/push; clr_err loses to a new error
    step(0, 0, 0, 1, 14'h0000, 0);
    step(0, 1, 0, 0, '0, 0);
    step(1, 1, 0, 1, 14'h1234, 0);
    chk("t6_sp", 32'(sp_w[0]), 32'h3FFF);
    chk("t6_flags", {30'd0, ovf_w[0], unf_w[0]}, 32'd0);
    step(0, 0, 1, 0, '0, 1);
    chk("t6_underflow", 32'(unf_w[0]), 32'd1);

    // Random phase, checked every cycle by the compare process.
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0,
           pick_val(),
           $urandom_range(0, 9) == 0);
    end
    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
